// File: rtl/spu_pipe_pkg.sv
// Shared SPU pipeline types: the decoded per-lane instruction record carried from ID into REG.
package spu_pipe_pkg;

    localparam int OPCODE_W   = 11;
    localparam int REG_ADDR_W = 7;

    typedef struct packed {
        logic                  regWriteEnable;
        logic                  source;
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] rA;
        logic [REG_ADDR_W-1:0] rB;
        logic [REG_ADDR_W-1:0] rC;
        logic [REG_ADDR_W-1:0] rT;
        logic [6:0]            imm7;
        logic [9:0]            imm10;
        logic [15:0]           imm16;
        logic [17:0]           imm18;
    } id_lane_t;

    localparam int ID_LANE_W = $bits(id_lane_t);

endpackage

// File: rtl/spu_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module spu_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spu_id_reg_pipe.sv
// Stallable, flushable ID->REG stage register with a 2-entry skid buffer and per-lane squash.
// Optional stall counter enabled by defining SPU_ID_REG_PIPE_PERF_EN.
module spu_id_reg_pipe
    import spu_pipe_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = ID_LANE_W,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*DATA_W-1:0] in_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*DATA_W-1:0] out_payload,
    output logic [1:0]              occupancy
`ifdef SPU_ID_REG_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]        stall_cycles
`endif
);

    // An entry is occupied exactly when at least one lane is valid: all-bubble bundles are never stored.
    logic [LANES-1:0]        main_lv, main_lv_d;
    logic [LANES-1:0]        skid_lv, skid_lv_d;
    logic [LANES*DATA_W-1:0] main_pl, main_pl_d;
    logic [LANES*DATA_W-1:0] skid_pl, skid_pl_d;
    logic [LANES*DATA_W-1:0] in_pl_sq;
    logic                    in_ready_q, in_ready_d;
    logic                    main_full, skid_full;
    logic                    in_fire, out_fire, in_take;

    assign main_full = |main_lv;
    assign skid_full = |skid_lv;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign in_take   = in_fire & (|in_lane_valid);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        in_pl_sq = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_lane_valid[l]) begin
                in_pl_sq[l*DATA_W +: DATA_W] = in_payload[l*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        main_lv_d = main_lv;
        main_pl_d = main_pl;
        skid_lv_d = skid_lv;
        skid_pl_d = skid_pl;

        if (flush) begin
            main_lv_d = '0;
            skid_lv_d = '0;
        end else if (!main_full) begin
            if (in_take) begin
                main_lv_d = in_lane_valid;
                main_pl_d = in_pl_sq;
            end
        end else if (out_fire) begin
            if (skid_full) begin
                main_lv_d = skid_lv;
                main_pl_d = skid_pl;
                skid_lv_d = in_take ? in_lane_valid : '0;
                if (in_take) begin
                    skid_pl_d = in_pl_sq;
                end
            end else begin
                main_lv_d = in_take ? in_lane_valid : '0;
                if (in_take) begin
                    main_pl_d = in_pl_sq;
                end
            end
        end else if (in_take) begin
            // in_ready was high, so the skid entry is known to be empty here.
            skid_lv_d = in_lane_valid;
            skid_pl_d = in_pl_sq;
        end

        in_ready_d = !(|skid_lv_d);
    end

    // NOTE: payload flops are reset too, because out_payload must read zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_lv    <= '0;
            main_pl    <= '0;
            skid_lv    <= '0;
            skid_pl    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            main_lv    <= main_lv_d;
            main_pl    <= main_pl_d;
            skid_lv    <= skid_lv_d;
            skid_pl    <= skid_pl_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = main_full;
    assign out_lane_valid = main_lv;
    assign out_payload    = main_pl;
    assign occupancy      = {main_full & skid_full, main_full ^ skid_full};

`ifdef SPU_ID_REG_PIPE_PERF_EN
    spu_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_spu_id_reg_pipe.sv
// Directed bench for spu_id_reg_pipe: queue-level reference model plus literal spot checks.
module tb_spu_id_reg_pipe;
    import spu_pipe_pkg::*;

    localparam int LANES = 2;
    localparam int DW    = ID_LANE_W;
    localparam int LW    = LANES * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b1;
    logic          in_ready;
    logic [1:0]    in_lane_valid = 2'b11;
    logic [LW-1:0] in_payload = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_lane_valid;
    logic [LW-1:0] out_payload;
    logic [1:0]    occupancy;
`ifdef SPU_ID_REG_PIPE_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spu_id_reg_pipe #(.LANES(LANES), .DATA_W(DW), .CNT_W(32)) dut (
`ifdef SPU_ID_REG_PIPE_PERF_EN
        .stall_cycles   (stall_cycles),
`endif
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_payload     (in_payload),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_payload    (out_payload),
        .occupancy      (occupancy)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: FIFO of at most two stored bundles ----------------
    typedef struct {
        logic [1:0]    lv;
        logic [LW-1:0] pl;
    } bundle_t;

    bundle_t     q[$];
    bit          m_rdy   = 1'b0;
    logic [31:0] m_stall = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_rdy   = 1'b0;
            m_stall = '0;
        end else begin
            bit      ofire, ifire;
            bundle_t b;
            ofire = (q.size() != 0) && out_ready;
            ifire = in_valid && m_rdy;
            if ((q.size() != 0) && !out_ready && (m_stall != '1)) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire && (in_lane_valid != 2'b00)) begin
                    b.lv = in_lane_valid;
                    for (int l = 0; l < LANES; l++)
                        b.pl[l*DW +: DW] = in_lane_valid[l] ? in_payload[l*DW +: DW] : '0;
                    q.push_back(b);
                end
            end
            m_rdy = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, q.size() != 0);
        check("occupancy", occupancy, q.size());
        check("in_ready", in_ready, m_rdy);
        if (q.size() != 0) begin
            check("out_lane_valid", out_lane_valid, q[0].lv);
            check("out_payload", out_payload, q[0].pl);
        end
`ifdef SPU_ID_REG_PIPE_PERF_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
    end

    // ---------------- stimulus helpers ----------------
    function automatic id_lane_t mk(input logic [10:0] op, input logic [6:0] rt);
        id_lane_t x;
        x = '0;
        x.regWriteEnable = 1'b1;
        x.source = op[0];
        x.opcode = op;
        x.rA     = rt + 7'd1;
        x.rB     = rt + 7'd2;
        x.rT     = rt;
        x.imm16  = {5'h0, op};
        x.imm18  = {7'h55, op};
        return x;
    endfunction

    function automatic logic [LW-1:0] bun(input logic [10:0] op0, input logic [10:0] op1);
        return {mk(op1, 7'd9), mk(op0, 7'd3)};
    endfunction

    // Drive one cycle's inputs at a negedge and return at the following negedge.
    task automatic step(input logic v, input logic [1:0] lv, input logic [LW-1:0] pl,
                        input logic ordy, input logic fl);
        in_valid = v; in_lane_valid = lv; in_payload = pl; out_ready = ordy; flush = fl;
        @(negedge clk);
    endtask

    function automatic logic [10:0] op_of(input logic [LW-1:0] p, input int lane);
        id_lane_t x;
        x = p[lane*DW +: DW];
        return x.opcode;
    endfunction

    logic [LW-1:0] a_b, b_b, c_b;
    logic [31:0]   stall0;

    initial begin
        // Reset held with a bundle offered.
        in_payload = bun(11'h7FF, 11'h7FE);
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst occupancy", occupancy, 0);
        check("rst out_payload", out_payload, 0);
        check("rst out_lane_valid", out_lane_valid, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("in_ready after release", in_ready, 1);

        // Streaming, one bundle per cycle.
        for (int i = 0; i < 8; i++) begin
            step(1, 2'b11, bun(11'h0C0 + 11'(i), 11'h1C0 + 11'(i)), 1, 0);
            check("stream valid", out_valid, 1);
            check("stream lane0 op", op_of(out_payload, 0), 11'h0C0 + 11'(i));
            check("stream lane1 op", op_of(out_payload, 1), 11'h1C0 + 11'(i));
            check("stream occ", occupancy, 1);
        end
        step(0, 2'b11, '0, 1, 0);
        check("stream drained", out_valid, 0);

        // Backpressure: A held, B skidded, C refused.
        a_b = bun(11'h0A0, 11'h1A0);
        b_b = bun(11'h0B0, 11'h1B0);
        c_b = bun(11'h0C5, 11'h1C5);
        step(1, 2'b11, a_b, 0, 0);
        check("bp A out", out_payload, a_b);
        step(1, 2'b11, b_b, 0, 0);
        check("bp occ2", occupancy, 2);
        check("bp in_ready low", in_ready, 0);
        step(1, 2'b11, c_b, 0, 0);
        check("bp A held", out_payload, a_b);
        check("bp occ still 2", occupancy, 2);
        step(1, 2'b11, c_b, 1, 0);
        check("bp B next", out_payload, b_b);
        check("bp ready again", in_ready, 1);
        step(1, 2'b11, c_b, 1, 0);
        check("bp C last", out_payload, c_b);
        step(0, 2'b11, '0, 1, 0);
        check("bp drained", out_valid, 0);

        // Squash: lane0 invalid with regWriteEnable set must arrive zeroed.
        step(1, 2'b10, bun(11'h033, 11'h133), 0, 0);
        check("sq lane_valid", out_lane_valid, 2'b10);
        check("sq lane0 zero", out_payload[DW-1:0], 0);
        check("sq lane1 op", op_of(out_payload, 1), 11'h133);
        step(1, 2'b00, bun(11'h044, 11'h144), 0, 0);
        check("bubble occ", occupancy, 1);
        step(0, 2'b11, '0, 1, 0);
        check("sq drained", out_valid, 0);

`ifdef SPU_ID_REG_PIPE_PERF_EN
        stall0 = stall_cycles;
        step(1, 2'b11, a_b, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 2'b11, '0, 0, 0);
        check("perf +5", stall_cycles - stall0, 5);
`endif

        // Flush with both entries full and a bundle offered.
        step(1, 2'b11, a_b, 0, 0);
        step(1, 2'b11, b_b, 0, 0);
        check("fl occ2", occupancy, 2);
`ifdef SPU_ID_REG_PIPE_PERF_EN
        stall0 = stall_cycles;
`endif
        step(1, 2'b11, c_b, 0, 1);
        check("fl out_valid", out_valid, 0);
        check("fl occ", occupancy, 0);
        check("fl in_ready", in_ready, 1);
`ifdef SPU_ID_REG_PIPE_PERF_EN
        check("perf kept by flush", stall_cycles, stall0 + 1);
`endif
        // Flush that coincides with a real in_fire and out_fire.
        step(1, 2'b11, a_b, 1, 0);
        step(1, 2'b11, b_b, 1, 1);
        check("fl2 empty", out_valid, 0);
        step(1, 2'b11, c_b, 1, 0);
        check("fl2 new only", out_payload, c_b);

        // Reset mid-transfer discards contents.
        step(1, 2'b11, a_b, 0, 0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst2 out_valid", out_valid, 0);
        check("rst2 occ", occupancy, 0);
        check("rst2 in_ready", in_ready, 0);
`ifdef SPU_ID_REG_PIPE_PERF_EN
        check("perf reset", stall_cycles, 0);
`endif
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst2 ready", in_ready, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
